// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and sizing for the framebuffer arbiter: posted-write entry and read FSM states.
package fb_arb_pkg;

  localparam int FB_AW         = 15;
  localparam int FB_DW         = 32;
  localparam int FB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [3:0]       ble;
    logic [FB_DW-1:0] wdata;
  } fb_wr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_DATA
  } fb_rd_state_t;

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// Posted CPU write FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = FB_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push,
  input  fb_wr_t                   push_data,
  input  logic                     pop,
  output fb_wr_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  fb_wr_t        mem_q [DEPTH];
  fb_wr_t        mem_d [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[PW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is data only; emptiness is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: pixel fetch > posted CPU write > CPU read, one slot per cycle.
module vga_fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [AW-1:0]                cpu_addr,
  input  logic [3:0]                   cpu_ble,
  input  logic [DW-1:0]                cpu_wdata,
  output logic                         cpu_ready,
  output logic                         cpu_rvalid,
  output logic [DW-1:0]                cpu_rdata,
  input  logic                         pix_req,
  input  logic [AW-1:0]                pix_addr,
  output logic                         pix_rvalid,
  output logic [DW-1:0]                pix_rdata,
  output logic                         ram_en,
  output logic [3:0]                   ram_we,
  output logic [AW-1:0]                ram_addr,
  output logic [DW-1:0]                ram_wdata,
  input  logic [DW-1:0]                ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  fb_rd_state_t  rd_state_q, rd_state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          pix_vld_q, pix_vld_d;

  fb_wr_t        wr_entry;
  fb_wr_t        wr_head;
  logic          fifo_full, fifo_empty;
  logic          rd_busy, wr_push, wr_pop, rd_accept, rd_issue;

  // AW/DW are expected to match the package widths that size fb_wr_t.
  assign wr_entry = '{addr: cpu_addr, ble: cpu_ble, wdata: cpu_wdata};

  assign rd_busy   = (rd_state_q != RD_IDLE);
  assign cpu_ready = !rd_busy && (cpu_we ? !fifo_full : 1'b1);
  assign wr_push   = cpu_req && cpu_we && cpu_ready;
  assign rd_accept = cpu_req && !cpu_we && cpu_ready;
  assign wr_pop    = !pix_req && !fifo_empty;
  // Reads wait for an empty FIFO so they observe every earlier posted write.
  assign rd_issue  = (rd_state_q == RD_WAIT) && !pix_req && fifo_empty;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .push      (wr_push),
    .push_data (wr_entry),
    .pop       (wr_pop),
    .head      (wr_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_accept) begin
          rd_addr_d  = cpu_addr;
          rd_state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_issue) rd_state_d = RD_DATA;
      end
      RD_DATA: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign pix_vld_d = pix_req;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_state_q <= RD_IDLE;
      pix_vld_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      pix_vld_q  <= pix_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
  end

  // Slot mux; the RAM port is held quiet while reset is asserted.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (resetb) begin
      if (pix_req) begin
        ram_en   = 1'b1;
        ram_addr = pix_addr;
      end else if (!fifo_empty) begin
        ram_en    = 1'b1;
        ram_we    = wr_head.ble;
        ram_addr  = wr_head.addr;
        ram_wdata = wr_head.wdata;
      end else if (rd_state_q == RD_WAIT) begin
        ram_en   = 1'b1;
        ram_addr = rd_addr_q;
      end
    end
  end

  assign cpu_rvalid = (rd_state_q == RD_DATA);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign pix_rvalid = pix_vld_q;
  assign pix_rdata  = ram_rdata;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA pixel fetcher and the YRV MCU data bus. It owns one 32K×32 synchronous single-port RAM holding both 64 KB framebuffer banks (word address bit 14 = bank). Each cycle it grants the RAM slot to the pixel fetcher, a buffered CPU write, or a CPU read. Pixel reads have fixed latency, so the VGA scan-out never starves; CPU writes are posted into a 4-entry FIFO.

## Interface
- `FIFO_DEPTH`, 4: CPU write FIFO entries; must be a power of 2, at least 2.
- `AW`, 15: RAM word address width.
- `DW`, 32: RAM data width.
- `clk` in 1: single system clock; all ports are synchronous to it.
- `resetb` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU word address.
- `cpu_ble` in 4: byte-lane enables for writes.
- `cpu_wdata` in DW: write data.
- `cpu_ready` out 1: request accepted when `cpu_req && cpu_ready`.
- `cpu_rvalid` out 1: one-cycle pulse; `cpu_rdata` is valid.
- `cpu_rdata` out DW: read data.
- `pix_req` in 1: pixel word fetch request.
- `pix_addr` in AW: pixel word address.
- `pix_rvalid` out 1: pixel data valid.
- `pix_rdata` out DW: pixel word.
- `ram_en` out 1: RAM access this cycle.
- `ram_we` out 4: byte write enables; 0 = read.
- `ram_addr` out AW: RAM address.
- `ram_wdata` out DW: RAM write data.
- `ram_rdata` in DW: RAM read data, valid 1 cycle after a read.
- `fifo_level` out 3: current write FIFO occupancy, 0..4.

## Operation
- **Slot priority each cycle**, strict:
  1. `pix_req`.
  2. FIFO head write, if the FIFO is non-empty.
  3. Pending CPU read, only when the FIFO is empty.
- **RAM port drive** is combinational from the slot winner. When no requester is present: `ram_en=0`, `ram_we=0`.
- **Write accept:** `cpu_ready = !rd_busy && (cpu_we ? !full : 1)`.
  - An accepted write pushes {addr, ble, wdata}.
  - Write entries drain in FIFO order, with `ram_we = entry.ble`.
  - A `ble=0` entry is pushed and drained as a no-op access with `ram_en=1`, `ram_we=0`. Its read data is discarded.
- **Read FSM**:
  - RD_IDLE: an accepted read latches `cpu_addr`, then goes to RD_WAIT.
  - RD_WAIT: when the FIFO is empty and `pix_req=0`, issue the read, then go to RD_DATA.
  - RD_DATA: `cpu_rvalid=1`, `cpu_rdata=ram_rdata`, then return to RD_IDLE.
  - `rd_busy` is 1 in RD_WAIT and RD_DATA.
- **Read-after-write ordering:** a read is never issued while the FIFO holds entries. This guarantees it observes every earlier accepted write.
- **Pixel path:** `pix_rvalid` is `pix_req` delayed one cycle. `pix_rdata = ram_rdata` (pass-through).
- **Simultaneous push and pop** (FIFO not full): allowed; `fifo_level` stays the same.
- **Push when full:** cannot occur because `cpu_ready=0`.
- **Starvation:** pixel traffic under real scan-out is at most 1 request per 4 cycles. Continuous `pix_req` stalls CPU traffic indefinitely; this is legal, with no timeout.
- **Reset, including mid-operation:**
  - FIFO emptied and read FSM to RD_IDLE.
  - `fifo_level=0`.
  - `cpu_rvalid`, `pix_rvalid`, `ram_en`, `ram_we` = 0.
  - `ram_addr`, `ram_wdata`, `cpu_rdata` = 0.
  - In-flight posted writes are lost.

## Timing
- **Pixel latency:** exactly 1 cycle, `pix_req` at cycle n → `pix_rvalid` at n+1, unconditionally.
- **Write:** accepted at n; earliest RAM write at n+1; later by one cycle per pixel slot or per older entry.
- **Read:** accepted at n with the FIFO empty and no `pix_req` at n+1 → issued at n+1, `cpu_rvalid` at n+2.
- **`cpu_ready`:** combinational from FIFO/FSM state and `cpu_we`. It has no combinational dependency on `pix_req`.
- **`fifo_level` and FSM state:** registered, updated on the clock edge after the accept or drain.

## Structure
- **Package `fb_arb_pkg`** holds:
  - Constants `FB_AW=15`, `FB_DW=32`, `FB_FIFO_DEPTH=4`.
  - `typedef struct packed {addr, ble, wdata} fb_wr_t`.
  - `typedef enum {RD_IDLE, RD_WAIT, RD_DATA} fb_rd_state_t`.
- **Sub-module `fb_wr_fifo`:** synchronous FIFO of `fb_wr_t`, with push/pop/full/empty/level and async active-low reset. Pointers carry an extra wrap bit.
- **Top `vga_fb_arbiter`:** slot mux, read FSM and pixel valid pipe. The RAM is instantiated outside the arbiter, at board top.

## Test plan
1. **Reset mid-burst:** with `fifo_level=3` and RD_WAIT, pulse `resetb` low → `fifo_level=0`, `cpu_ready=1`, no `cpu_rvalid`, all RAM outputs 0.
2. **FIFO full:** hold `pix_req=1` and issue 5 writes to addresses 0x0100..0x0104 → 4 accepted; `cpu_ready=0` on the fifth; `fifo_level=4`; no `ram_we`. Drop `pix_req` → four consecutive writes, in address order; then the fifth is accepted.
3. **Pixel preempts write:** FIFO holds 1 entry; `pix_req` with `pix_addr=0x4ABC` at n → `ram_addr=0x4ABC`, `ram_we=0` at n; `pix_rvalid=1` with the RAM word at n+1; FIFO write at n+1.
4. **Read-after-write:** write 0x00001234 to word 0x0010 with `ble=0011`, then read 0x0010 → the read is issued only after the drain; `cpu_rdata[15:0]=0x1234`; upper bytes unchanged from their prior contents.
5. **Read starvation:** `pix_req=1` for 100 cycles with a read pending → no `cpu_rvalid`, and `pix_rvalid` every cycle. Release → `cpu_rvalid` exactly 2 cycles later.
6. **Byte lanes:** write with `ble=1000`, data 0xA5000000 → `ram_we=1000` for one cycle; a readback returns 0xA5 in byte 3 with bytes 0–2 preserved.
